// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes op/funct into the ALU control code, forwards rs/rt from
// EX/MEM and MEM/WB, and registers the operands toward EX with load-use bubble and flush.
module alu_issue #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_op,
  input  logic [5:0]    in_funct,
  input  logic [RA-1:0] in_rs,
  input  logic [RA-1:0] in_rt,
  input  logic [RA-1:0] in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [W-1:0]  in_rs_val,
  input  logic [W-1:0]  in_rt_val,
  input  logic          mem_wen,
  input  logic [RA-1:0] mem_waddr,
  input  logic [W-1:0]  mem_wdata,
  input  logic          wb_wen,
  input  logic [RA-1:0] wb_waddr,
  input  logic [W-1:0]  wb_wdata,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  alu1,
  output logic [W-1:0]  alu2,
  output logic [3:0]    aluc,
  output logic [RA-1:0] out_waddr,
  output logic          out_wen,
  output logic          out_is_load,
  output logic [W-1:0]  out_store_data,
  output logic          illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUBBLE} state_t;
  typedef enum logic [1:0] {A1_RS, A1_SHAMT, A1_ZERO} a1_sel_t;

  typedef struct packed {
    logic [W-1:0]  alu1;
    logic [W-1:0]  alu2;
    logic [3:0]    aluc;
    logic [RA-1:0] waddr;
    logic          wen;
    logic          is_load;
    logic [W-1:0]  store_data;
    logic          illegal;
  } issue_t;

  state_t  r_state, w_state_nxt;
  issue_t  r_out, w_out_nxt;
  logic    w_load;

  a1_sel_t       w_a1_sel;
  logic          w_a2_imm, w_sext, w_use_rs, w_use_rt;
  logic [3:0]    w_aluc;
  logic [RA-1:0] w_waddr;
  logic          w_wen, w_is_load, w_illegal;
  logic [W-1:0]  w_rs_fwd, w_rt_fwd, w_imm_ext, w_alu1;
  logic          w_hazard;

  // Register 0 is hard-wired; the younger EX/MEM result wins over MEM/WB.
  function automatic logic [W-1:0] fwd(
    input logic [RA-1:0] idx,   input logic [W-1:0]  rf,
    input logic          m_wen, input logic [RA-1:0] m_addr, input logic [W-1:0] m_data,
    input logic          b_wen, input logic [RA-1:0] b_addr, input logic [W-1:0] b_data);
    if (idx == '0)                   return '0;
    else if (m_wen && m_addr == idx) return m_data;
    else if (b_wen && b_addr == idx) return b_data;
    else                             return rf;
  endfunction

  assign w_rs_fwd = fwd(in_rs, in_rs_val, mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata);
  assign w_rt_fwd = fwd(in_rt, in_rt_val, mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata);

  always_comb begin
    w_aluc    = ALU_ADD;
    w_a1_sel  = A1_RS;
    w_a2_imm  = 1'b0;
    w_sext    = 1'b0;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_waddr   = in_rt;
    w_wen     = 1'b0;
    w_is_load = 1'b0;
    w_illegal = 1'b0;
    case (in_op)
      6'b000000: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_waddr  = in_rd;
        w_wen    = (in_rd != '0);
        case (in_funct)
          6'b100000, 6'b100001: w_aluc = ALU_ADD;
          6'b100010, 6'b100011: w_aluc = ALU_SUB;
          6'b100100:            w_aluc = ALU_AND;
          6'b100101:            w_aluc = ALU_OR;
          6'b100110:            w_aluc = ALU_XOR;
          6'b100111:            w_aluc = ALU_NOR;
          6'b101010:            w_aluc = ALU_SLT;
          6'b101011:            w_aluc = ALU_SLTU;
          6'b000000: begin w_aluc = ALU_SLL; w_a1_sel = A1_SHAMT; w_use_rs = 1'b0; end
          6'b000010: begin w_aluc = ALU_SRL; w_a1_sel = A1_SHAMT; w_use_rs = 1'b0; end
          6'b000011: begin w_aluc = ALU_SRA; w_a1_sel = A1_SHAMT; w_use_rs = 1'b0; end
          6'b000100:            w_aluc = ALU_SLL;
          6'b000110:            w_aluc = ALU_SRL;
          6'b000111:            w_aluc = ALU_SRA;
          default: begin
            w_illegal = 1'b1;
            w_wen     = 1'b0;
            w_use_rs  = 1'b0;
            w_use_rt  = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001001: begin
        w_aluc = ALU_ADD;  w_a2_imm = 1'b1; w_sext = 1'b1; w_use_rs = 1'b1; w_wen = (in_rt != '0);
      end
      6'b001010: begin
        w_aluc = ALU_SLT;  w_a2_imm = 1'b1; w_sext = 1'b1; w_use_rs = 1'b1; w_wen = (in_rt != '0);
      end
      6'b001011: begin
        w_aluc = ALU_SLTU; w_a2_imm = 1'b1; w_sext = 1'b1; w_use_rs = 1'b1; w_wen = (in_rt != '0);
      end
      6'b001100: begin
        w_aluc = ALU_AND;  w_a2_imm = 1'b1; w_use_rs = 1'b1; w_wen = (in_rt != '0);
      end
      6'b001101: begin
        w_aluc = ALU_OR;   w_a2_imm = 1'b1; w_use_rs = 1'b1; w_wen = (in_rt != '0);
      end
      6'b001110: begin
        w_aluc = ALU_XOR;  w_a2_imm = 1'b1; w_use_rs = 1'b1; w_wen = (in_rt != '0);
      end
      6'b001111: begin
        w_aluc = ALU_LUI;  w_a2_imm = 1'b1; w_a1_sel = A1_ZERO; w_wen = (in_rt != '0);
      end
      6'b100011: begin
        w_aluc = ALU_ADD;  w_a2_imm = 1'b1; w_sext = 1'b1; w_use_rs = 1'b1;
        w_wen  = (in_rt != '0);
        w_is_load = 1'b1;
      end
      6'b101011: begin
        w_aluc = ALU_ADD;  w_a2_imm = 1'b1; w_sext = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_imm_ext = w_sext ? {{(W-16){in_imm[15]}}, in_imm} : {{(W-16){1'b0}}, in_imm};

  always_comb begin
    case (w_a1_sel)
      A1_SHAMT: w_alu1 = {{(W-5){1'b0}}, in_shamt};
      A1_ZERO:  w_alu1 = '0;
      default:  w_alu1 = w_rs_fwd;
    endcase
  end

  always_comb begin
    w_out_nxt            = '0;
    w_out_nxt.alu1       = w_alu1;
    w_out_nxt.alu2       = w_a2_imm ? w_imm_ext : w_rt_fwd;
    w_out_nxt.aluc       = w_aluc;
    w_out_nxt.waddr      = w_waddr;
    w_out_nxt.wen        = w_wen;
    w_out_nxt.is_load    = w_is_load;
    w_out_nxt.store_data = w_rt_fwd;
    w_out_nxt.illegal    = w_illegal;
  end

  // The held load's data is not forwardable until it reaches MEM/WB.
  assign w_hazard = (r_state == S_FULL) && r_out.is_load && r_out.wen &&
                    ((w_use_rs && in_rs == r_out.waddr) || (w_use_rt && in_rt == r_out.waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    in_ready    = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          in_ready = out_ready && !w_hazard;
          if (out_ready) begin
            if (in_valid && !w_hazard) w_load = 1'b1;
            else if (in_valid)         w_state_nxt = S_BUBBLE;
            else                       w_state_nxt = S_EMPTY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out <= '0;
    else if (w_load) r_out <= w_out_nxt;
  end

  assign out_valid      = (r_state == S_FULL);
  assign alu1           = r_out.alu1;
  assign alu2           = r_out.alu2;
  assign aluc           = r_out.aluc;
  assign out_waddr      = r_out.waddr;
  assign out_wen        = r_out.wen;
  assign out_is_load    = r_out.is_load;
  assign out_store_data = r_out.store_data;
  assign illegal        = r_out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions push hand-computed results,
// a negedge monitor pops and compares whenever EX takes an output.
module tb_alu_issue;
  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [5:0]    in_op = '0, in_funct = '0;
  logic [RA-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [4:0]    in_shamt = '0;
  logic [15:0]   in_imm = '0;
  logic [W-1:0]  in_rs_val = '0, in_rt_val = '0;
  logic          mem_wen = 1'b0, wb_wen = 1'b0;
  logic [RA-1:0] mem_waddr = '0, wb_waddr = '0;
  logic [W-1:0]  mem_wdata = '0, wb_wdata = '0;
  logic          flush = 1'b0, out_ready = 1'b1;
  logic          out_valid, out_wen, out_is_load, illegal;
  logic [W-1:0]  alu1, alu2, out_store_data;
  logic [3:0]    aluc;
  logic [RA-1:0] out_waddr;

  alu_issue #(.W(W), .RA(RA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .alu1(alu1), .alu2(alu2), .aluc(aluc), .out_waddr(out_waddr), .out_wen(out_wen),
    .out_is_load(out_is_load), .out_store_data(out_store_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a1, a2, sd;
    logic [3:0]  c;
    logic [4:0]  wa;
    logic        wen, ld, ill;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   w, tot;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] a1, a2, sd, input logic [3:0] c,
                              input logic [4:0] wa, input logic wen, ld, ill);
    exp_t e;
    e.id = id; e.a1 = a1; e.a2 = a2; e.sd = sd; e.c = c;
    e.wa = wa; e.wen = wen; e.ld = ld; e.ill = ill;
    return e;
  endfunction

  // Drive one instruction and hold it until the stage accepts it.
  task automatic issue(input int id, input logic [5:0] op, fn, input logic [4:0] rs, rt, rd, sh,
                       input logic [15:0] imm, input logic [31:0] rsv, rtv, input exp_t e,
                       output int waits);
    logic acc;
    in_valid = 1'b1; in_op = op; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_rs_val = rsv; in_rt_val = rtv;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 20) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        acc = 1'b1;
      end else waits++;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", id, {31'b0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fwd_set(input logic mw, input logic [4:0] ma, input logic [31:0] md,
                         input logic bw, input logic [4:0] ba, input logic [31:0] bd);
    mem_wen = mw; mem_waddr = ma; mem_wdata = md;
    wb_wen = bw; wb_waddr = ba; wb_wdata = bd;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_out: got out_valid=1 want no pending instruction");
      end else begin
        m_e = sb.pop_front();
        chk("aluc", m_e.id, {28'b0, aluc}, {28'b0, m_e.c});
        chk("wen", m_e.id, {31'b0, out_wen}, {31'b0, m_e.wen});
        chk("illegal", m_e.id, {31'b0, illegal}, {31'b0, m_e.ill});
        if (!m_e.ill) begin
          chk("alu1", m_e.id, alu1, m_e.a1);
          chk("alu2", m_e.id, alu2, m_e.a2);
          chk("store_data", m_e.id, out_store_data, m_e.sd);
          chk("is_load", m_e.id, {31'b0, out_is_load}, {31'b0, m_e.ld});
          if (m_e.wen) chk("waddr", m_e.id, {27'b0, out_waddr}, {27'b0, m_e.wa});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 0, {31'b0, out_valid}, 32'd0);
    chk("rst_ready", 0, {31'b0, in_ready}, 32'd1);
    chk("rst_alu1", 0, alu1, 32'd0);
    chk("rst_alu2", 0, alu2, 32'd0);
    chk("rst_ctl", 0, {20'b0, aluc, out_waddr, out_wen, out_is_load, illegal}, 32'd0);
    chk("rst_sd", 0, out_store_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add $3,$1,$2 from empty
    issue(1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7,
          mk(1, 32'd5, 32'd7, 32'd7, 4'b0000, 5'd3, 1, 0, 0), w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", 1, {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;

    tot = 0;
    issue(2, 6'b000000, 6'b100010, 5'd1, 5'd2, 5'd5, 5'd0, 16'h0, 32'd9, 32'd4,
          mk(2, 32'd9, 32'd4, 32'd4, 4'b0001, 5'd5, 1, 0, 0), w); tot += w;
    issue(3, 6'b000000, 6'b000011, 5'd0, 5'd2, 5'd4, 5'd4, 16'h0, 32'd0, 32'h80000000,
          mk(3, 32'd4, 32'h80000000, 32'h80000000, 4'b1100, 5'd4, 1, 0, 0), w); tot += w;
    issue(4, 6'b000000, 6'b000111, 5'd9, 5'd2, 5'd7, 5'd0, 16'h0, 32'h23, 32'h10,
          mk(4, 32'h23, 32'h10, 32'h10, 4'b1100, 5'd7, 1, 0, 0), w); tot += w;
    issue(5, 6'b001111, 6'b000000, 5'd3, 5'd8, 5'd0, 5'd0, 16'h8001, 32'h1234, 32'h77,
          mk(5, 32'd0, 32'h00008001, 32'h77, 4'b1000, 5'd8, 1, 0, 0), w); tot += w;
    issue(6, 6'b001000, 6'b000000, 5'd1, 5'd9, 5'd0, 5'd0, 16'hFFFF, 32'd10, 32'd0,
          mk(6, 32'd10, 32'hFFFFFFFF, 32'd0, 4'b0000, 5'd9, 1, 0, 0), w); tot += w;
    issue(7, 6'b001100, 6'b000000, 5'd1, 5'd10, 5'd0, 5'd0, 16'hFFFF, 32'd10, 32'd0,
          mk(7, 32'd10, 32'h0000FFFF, 32'd0, 4'b0100, 5'd10, 1, 0, 0), w); tot += w;
    issue(8, 6'b000000, 6'b101011, 5'd1, 5'd2, 5'd11, 5'd0, 16'h0, 32'd3, 32'hFFFFFFFF,
          mk(8, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1011, 5'd11, 1, 0, 0), w); tot += w;
    issue(9, 6'b001010, 6'b000000, 5'd1, 5'd12, 5'd0, 5'd0, 16'h8000, 32'd1, 32'd0,
          mk(9, 32'd1, 32'hFFFF8000, 32'd0, 4'b1010, 5'd12, 1, 0, 0), w); tot += w;
    issue(10, 6'b101011, 6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0008, 32'h100, 32'hCAFE,
          mk(10, 32'h100, 32'd8, 32'hCAFE, 4'b0000, 5'd2, 0, 0, 0), w); tot += w;
    issue(11, 6'b000000, 6'b100111, 5'd1, 5'd2, 5'd13, 5'd0, 16'h0, 32'hF0, 32'h0F,
          mk(11, 32'hF0, 32'h0F, 32'h0F, 4'b0111, 5'd13, 1, 0, 0), w); tot += w;
    issue(12, 6'b000000, 6'b000000, 5'd5, 5'd2, 5'd14, 5'd31, 16'h0, 32'h999, 32'd1,
          mk(12, 32'd31, 32'd1, 32'd1, 4'b1110, 5'd14, 1, 0, 0), w); tot += w;
    fwd_set(1, 5'd4, 32'hAA, 1, 5'd4, 32'hBB);
    issue(13, 6'b000000, 6'b100101, 5'd4, 5'd2, 5'd12, 5'd0, 16'h0, 32'h11, 32'h22,
          mk(13, 32'hAA, 32'h22, 32'h22, 4'b0101, 5'd12, 1, 0, 0), w); tot += w;
    fwd_set(1, 5'd7, 32'hAA, 1, 5'd4, 32'hBB);
    issue(14, 6'b000000, 6'b100110, 5'd2, 5'd4, 5'd13, 5'd0, 16'h0, 32'h22, 32'h44,
          mk(14, 32'h22, 32'hBB, 32'hBB, 4'b0110, 5'd13, 1, 0, 0), w); tot += w;
    fwd_set(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    issue(15, 6'b000000, 6'b100100, 5'd0, 5'd2, 5'd14, 5'd0, 16'h0, 32'h99, 32'h22,
          mk(15, 32'd0, 32'h22, 32'h22, 4'b0100, 5'd14, 1, 0, 0), w); tot += w;
    fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    issue(16, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'd1, 32'd2,
          mk(16, 32'd1, 32'd2, 32'd2, 4'b0000, 5'd0, 0, 0, 0), w); tot += w;
    chk("b2b_stall_cycles", 16, tot, 32'd0);
    idle(2);

    // load-use: lw $5 then add $6,$5,$1
    issue(17, 6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0004, 32'h100, 32'd0,
          mk(17, 32'h100, 32'd4, 32'd0, 4'b0000, 5'd5, 1, 1, 0), w);
    in_valid = 1'b1; in_op = 6'b000000; in_funct = 6'b100000;
    in_rs = 5'd5; in_rt = 5'd1; in_rd = 5'd6; in_rs_val = 32'hDEAD; in_rt_val = 32'd3;
    @(negedge clk);
    chk("lu_stall_ready", 18, {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_bubble_valid", 18, {31'b0, out_valid}, 32'd0);
    chk("lu_bubble_ready", 18, {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    fwd_set(0, 5'd0, 32'h0, 1, 5'd5, 32'h55);
    issue(18, 6'b000000, 6'b100000, 5'd5, 5'd1, 5'd6, 5'd0, 16'h0, 32'hDEAD, 32'd3,
          mk(18, 32'h55, 32'd3, 32'd3, 4'b0000, 5'd6, 1, 0, 0), w);
    chk("lu_retry_wait", 18, w, 32'd0);
    fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idle(2);

    // backpressure, then flush the held instruction
    out_ready = 1'b0;
    issue(19, 6'b000000, 6'b100010, 5'd1, 5'd2, 5'd15, 5'd0, 16'h0, 32'd1, 32'd2,
          mk(19, 32'd1, 32'd2, 32'd2, 4'b0001, 5'd15, 1, 0, 0), w);
    in_valid = 1'b1; in_funct = 6'b100000; in_rd = 5'd16;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 19, {31'b0, in_ready}, 32'd0);
      chk("bp_valid", 19, {31'b0, out_valid}, 32'd1);
      chk("bp_alu1", 19, alu1, 32'd1);
      chk("bp_alu2", 19, alu2, 32'd2);
      chk("bp_aluc", 19, {28'b0, aluc}, 32'd1);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 19, {31'b0, in_ready}, 32'd0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", 19, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // illegal encodings still reach EX
    issue(20, 6'b111111, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd1, 32'd2,
          mk(20, 32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 0, 0, 1), w);
    issue(21, 6'b000000, 6'b001000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd1, 32'd2,
          mk(21, 32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 0, 0, 1), w);
    idle(4);
    chk("sb_drain", 0, sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- ID/EX issue stage of the pipelined CPU; drives the ALU operand/control interface (alu1, alu2, aluc).
- Accepts one decoded instruction per cycle from ID via valid/ready and decodes op/funct into the 4-bit aluc code.
- Selects operands, applying EX/MEM and MEM/WB forwarding, then registers them toward EX.
- Inserts a one-cycle bubble on a load-use hazard and honours flush.

Parameters:
- W, 32, datapath width.
- RA, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  6  opcode.
- in_funct  in  6  R-type funct.
- in_rs, in_rt, in_rd  in  RA  register indices.
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate.
- in_rs_val, in_rt_val  in  W  register-file read data.
- mem_wen, mem_waddr, mem_wdata  in  1/RA/W  EX/MEM forwarding source; never a load.
- wb_wen, wb_waddr, wb_wdata  in  1/RA/W  MEM/WB forwarding source.
- flush  in  1  kill the held and the incoming instruction.
- out_ready  in  1  EX accepts.
- out_valid  out  1  registered outputs are valid.
- alu1, alu2  out  W  ALU operands.
- aluc  out  4  ALU control.
- out_waddr  out  RA  destination register.
- out_wen  out  1  destination is written.
- out_is_load  out  1  instruction is lw.
- out_store_data  out  W  forwarded rt value for sw.
- illegal  out  1  undecodable opcode/funct.

Behaviour:
- All outputs are registered. Async reset forces every output to 0, except in_ready, which is 1 since it is combinational from the EMPTY state.
- aluc encoding:
  - 0000 add, 0001 sub.
  - 0100 and, 0101 or, 0110 xor, 0111 nor.
  - 1000 lui (ALU returns alu2<<16), 1010 slt, 1011 sltu.
  - 1100 sra, 1101 srl, 1110 sll. Shift amount is taken from alu1[4:0] and the value from alu2.
- R-type decode (op=0), funct -> aluc:
  - 100000/100001 -> 0000; 100010/100011 -> 0001.
  - 100100/100101/100110/100111 -> 0100/0101/0110/0111.
  - 101010 -> 1010; 101011 -> 1011.
  - For the above: alu1=rs, alu2=rt.
  - 000000/000010/000011 -> 1110/1101/1100, with alu1={27'b0,shamt}, alu2=rt.
  - 000100/000110/000111 -> the same shifts with alu1=rs.
  - Destination: out_waddr=rd, out_wen=(rd!=0).
- I-type decode (alu1=rs, dest rt):
  - addi/addiu -> 0000 sign-extended.
  - slti -> 1010 sign-extended; sltiu -> 1011 sign-extended.
  - andi/ori/xori -> 0100/0101/0110 zero-extended.
  - lui -> 1000, alu1=0, alu2=zero-extended imm.
  - lw (100011) -> 0000 sign-extended, is_load=1.
  - sw (101011) -> 0000 sign-extended, out_wen=0.
- Any other encoding: illegal=1, aluc=0000, out_wen=0, still passed to EX.
- Forwarding per source operand (rs, rt): mem match beats wb match beats register file. A match requires wen=1, waddr==idx, and idx!=0. Register 0 always reads 0.
- State machine:
  - EMPTY:
    - in_ready=1.
    - in_valid with no hazard -> load outputs, go to FULL.
  - FULL:
    - in_ready=out_ready AND no hazard.
    - out_ready && in_valid && no hazard -> reload (back-to-back, zero bubbles).
    - out_ready && in_valid && hazard -> go to BUBBLE.
    - out_ready && !in_valid -> go to EMPTY.
    - !out_ready -> hold all outputs stable.
  - BUBBLE: out_valid=0, in_ready=0 for exactly one cycle, then go to EMPTY. The stalled instruction is accepted next cycle with forwarding from MEM/WB.
- Hazard condition: the held instruction is a load with out_wen, and out_waddr equals the incoming rs or rt (whichever is used).
  - rt counts as used for R-type and for sw.
  - sll/srl/sra do not use rs.
- flush:
  - Synchronous; dominates all other events.
  - Next state EMPTY, out_valid=0, in_ready=0 in the flush cycle.
- Reset mid-transfer discards the held instruction; no partial output ever appears.

Test Plan:
- Reset and add: hold rst_n=0, then release. Issue add $3,$1,$2 with rs_val=5, rt_val=7 -> next cycle: out_valid=1, aluc=0000, alu1=5, alu2=7, out_waddr=3, out_wen=1.
- Shift and lui: sra with shamt=4 -> aluc=1100, alu1=4. srav with rs_val=0x23 -> alu1=0x23. lui imm=0x8001 -> aluc=1000, alu1=0, alu2=0x00008001.
- Extension: addi imm=0xFFFF -> alu2=0xFFFFFFFF. andi imm=0xFFFF -> alu2=0x0000FFFF.
- Forwarding: mem and wb both write $4 (0xAA and 0xBB) while rs=4 -> alu1=0xAA. Any write to $0 -> alu1=0.
- Load-use: lw $5, then add $6,$5,$1 -> in_ready=0 and a one-cycle bubble. The add then issues with alu1 = wb_wdata for $5.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Assert flush -> out_valid=0 next cycle. Illegal op 111111 -> illegal=1, out_wen=0.
